// File: rtl/argmax_arbiter_if.sv
// Handshake bundle between the requester layers, the arbiter and the shared argmax unit.
// master = arbiter side, slave = requesters plus argmax unit.
interface argmax_arbiter_if #(
    parameter int N = 3,
    parameter int R = 2
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0][N-1:0][31:0] req_v;
    logic [R-1:0]              req_v_stb;
    logic [R-1:0]              req_v_ack;
    logic [IW-1:0]             resp_i;
    logic [R-1:0]              resp_i_stb;
    logic [R-1:0]              resp_i_ack;
    logic [N-1:0][31:0]        am_input_v;
    logic                      am_input_v_stb;
    logic                      am_input_v_ack;
    logic [IW-1:0]             am_output_i;
    logic                      am_output_i_stb;
    logic                      am_output_i_ack;
    logic                      busy;
    logic [RW-1:0]             grant_id;

    modport master (
        input  req_v, req_v_stb, resp_i_ack, am_input_v_ack, am_output_i, am_output_i_stb,
        output req_v_ack, resp_i, resp_i_stb, am_input_v, am_input_v_stb, am_output_i_ack,
               busy, grant_id
    );

    modport slave (
        output req_v, req_v_stb, resp_i_ack, am_input_v_ack, am_output_i, am_output_i_stb,
        input  req_v_ack, resp_i, resp_i_stb, am_input_v, am_input_v_stb, am_output_i_ack,
               busy, grant_id
    );
endinterface

// File: rtl/argmax_arbiter.sv
// Round-robin arbiter sharing one argmax unit between R requesters; one job in flight,
// the granted vector is latched so the argmax unit never sees later req_v changes.
module argmax_arbiter #(
    parameter int N = 3,
    parameter int R = 2
) (
    input logic            clk,
    input logic            rst,
    argmax_arbiter_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, RETURN} state_t;

    state_t             state, state_nxt;
    logic [RW-1:0]      rr_ptr, grant_id, pick;
    logic               pick_ok;
    int                 pick_idx;
    logic [R-1:0]       grant_oh;
    logic [N-1:0][31:0] sel_v, vec_reg;
    logic [IW-1:0]      resp_q;
    logic               v_xfer, resp_xfer;

    // Scan from the highest offset down so the offset nearest rr_ptr wins.
    always_comb begin
        pick     = '0;
        pick_ok  = 1'b0;
        pick_idx = 0;
        for (int k = R - 1; k >= 0; k--) begin
            pick_idx = (int'(rr_ptr) + k) % R;
            if (bus.req_v_stb[pick_idx]) begin
                pick    = RW'(pick_idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        sel_v    = '0;
        for (int r = 0; r < R; r++) begin
            grant_oh[r] = (grant_id == RW'(r));
            if (grant_id == RW'(r)) sel_v = bus.req_v[r];
        end
    end

    // Only the granted requester's handshake bits take part.
    assign v_xfer    = (state == ACCEPT) && |(bus.req_v_stb & grant_oh);
    assign resp_xfer = (state == RETURN) && |(bus.resp_i_ack & grant_oh);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_ok)                 state_nxt = ACCEPT;
            ACCEPT:  if (v_xfer)                  state_nxt = ISSUE;
            ISSUE:   if (bus.am_input_v_ack)      state_nxt = WAIT;
            WAIT:    if (bus.am_output_i_stb)     state_nxt = RETURN;
            RETURN:  if (resp_xfer)               state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            vec_reg  <= '0;
            resp_q   <= '0;
        end else begin
            if (state == IDLE && pick_ok)              grant_id <= pick;
            if (v_xfer)                                vec_reg  <= sel_v;
            if (state == WAIT && bus.am_output_i_stb)  resp_q   <= bus.am_output_i;
            if (resp_xfer)                             rr_ptr   <= RW'((int'(grant_id) + 1) % R);
        end
    end

    // Every output is a decode of the state register or a plain register.
    assign bus.req_v_ack       = (state == ACCEPT) ? grant_oh : '0;
    assign bus.am_input_v      = vec_reg;
    assign bus.am_input_v_stb  = (state == ISSUE);
    assign bus.am_output_i_ack = (state == WAIT);
    assign bus.resp_i          = resp_q;
    assign bus.resp_i_stb      = (state == RETURN) ? grant_oh : '0;
    assign bus.busy            = (state != IDLE);
    assign bus.grant_id        = grant_id;
endmodule

// File: tb/tb_argmax_arbiter.sv
// Directed bench for argmax_arbiter: requester driver, behavioural argmax partner,
// a job-level reference model with a per-cycle compare, and literal expectations.
module tb_argmax_arbiter;
    localparam int N  = 3;
    localparam int R  = 2;
    localparam int IW = 2;
    localparam logic [31:0] F1 = 32'h3f80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;

    logic clk, rst;
    argmax_arbiter_if #(.N(N), .R(R)) bus ();
    argmax_arbiter #(.N(N), .R(R)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Float32 ordering via sign-magnitude to unsigned key; ties keep the lowest index.
    function automatic logic [31:0] fkey(input logic [31:0] b);
        return b[31] ? ~b : (b | 32'h8000_0000);
    endfunction

    function automatic int argmax_f(input logic [N-1:0][31:0] v);
        int best = 0;
        for (int i = 1; i < N; i++)
            if (fkey(v[i]) > fkey(v[best])) best = i;
        return best;
    endfunction

    // Main-owned controls
    int                 total[R];
    int                 resp_hold[R];
    int                 am_lat;
    int                 iso_cnt;
    logic [N-1:0][31:0] vec_cfg[R];
    logic [N-1:0][31:0] iso_vec;

    // Requester driver: stb held until acked, optional delay before resp_i_ack.
    int   started[R];
    int   hold_cnt[R];
    bit   waiting[R], xfer_pend[R], rsp_pend[R];
    int   iso_done;
    initial begin
        bus.req_v      = '0;
        bus.req_v_stb  = '0;
        bus.resp_i_ack = '0;
        iso_done       = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus.req_v_stb  = '0;
                bus.resp_i_ack = '0;
                for (int r = 0; r < R; r++) begin
                    started[r] = 0; hold_cnt[r] = 0;
                    waiting[r] = 0; xfer_pend[r] = 0; rsp_pend[r] = 0;
                end
            end else begin
                if (iso_done != iso_cnt) begin
                    bus.req_v[0] = iso_vec;
                    iso_done     = iso_cnt;
                end
                for (int r = 0; r < R; r++) begin
                    if (xfer_pend[r]) begin
                        bus.req_v_stb[r] = 1'b0;
                        xfer_pend[r]     = 0;
                        waiting[r]       = 1;
                        hold_cnt[r]      = resp_hold[r];
                    end else if (bus.req_v_stb[r] && bus.req_v_ack[r]) begin
                        xfer_pend[r] = 1;
                    end
                    if (rsp_pend[r]) begin
                        bus.resp_i_ack[r] = 1'b0;
                        rsp_pend[r]       = 0;
                        waiting[r]        = 0;
                    end else if (bus.resp_i_stb[r]) begin
                        if (hold_cnt[r] > 0) hold_cnt[r]--;
                        else begin
                            bus.resp_i_ack[r] = 1'b1;
                            rsp_pend[r]       = 1;
                        end
                    end
                    if (!bus.req_v_stb[r] && !waiting[r] && !xfer_pend[r] && started[r] < total[r]) begin
                        bus.req_v[r]     = vec_cfg[r];
                        bus.req_v_stb[r] = 1'b1;
                        started[r]++;
                    end
                end
            end
        end
    end

    // Behavioural argmax unit with programmable latency.
    int                 pst, cnt;
    logic               prev_ack;
    logic [N-1:0][31:0] am_vec;
    initial begin
        bus.am_input_v_ack  = 1'b0;
        bus.am_output_i     = '0;
        bus.am_output_i_stb = 1'b0;
        pst = 0; cnt = 0; prev_ack = 1'b0; am_vec = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus.am_input_v_ack  = 1'b0;
                bus.am_output_i_stb = 1'b0;
                bus.am_output_i     = '0;
                pst = 0;
            end else begin
                case (pst)
                    0: if (bus.am_input_v_stb) begin
                           bus.am_input_v_ack = 1'b1;
                           am_vec = bus.am_input_v;
                           pst = 1;
                       end
                    1: begin bus.am_input_v_ack = 1'b0; cnt = am_lat; pst = 2; end
                    2: if (cnt > 0) cnt--;
                       else begin
                           bus.am_output_i     = IW'(argmax_f(am_vec));
                           bus.am_output_i_stb = 1'b1;
                           prev_ack = bus.am_output_i_ack;
                           pst = 3;
                       end
                    default: if (prev_ack) begin
                                 bus.am_output_i_stb = 1'b0;
                                 pst = 0;
                             end else prev_ack = bus.am_output_i_ack;
                endcase
            end
        end
    end

    // Job-level reference: round-robin choice, latched vector, expected index.
    int                 rr, exp_grant, exp_idx;
    bit                 job_active, ack1_seen;
    logic [N-1:0][31:0] exp_vec;
    int                 grant_log[$], resp_r_log[$], resp_i_log[$];
    initial begin
        rr = 0; job_active = 0; exp_grant = 0; exp_idx = 0; exp_vec = '0; ack1_seen = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                rr = 0; job_active = 0; ack1_seen = 0;
                grant_log.delete(); resp_r_log.delete(); resp_i_log.delete();
            end else begin
                if (bus.req_v_ack[1]) ack1_seen = 1;
                if (!job_active && (bus.req_v_stb & bus.req_v_ack) != '0) begin
                    exp_grant = -1;
                    for (int k = 0; k < R; k++)
                        if (exp_grant < 0 && bus.req_v_stb[(rr + k) % R]) exp_grant = (rr + k) % R;
                    exp_vec    = bus.req_v[exp_grant];
                    exp_idx    = argmax_f(exp_vec);
                    job_active = 1;
                    grant_log.push_back(exp_grant);
                end else if (job_active && (bus.resp_i_stb & bus.resp_i_ack) != '0) begin
                    for (int r = 0; r < R; r++)
                        if (bus.resp_i_stb[r]) resp_r_log.push_back(r);
                    resp_i_log.push_back(int'(bus.resp_i));
                    rr         = (exp_grant + 1) % R;
                    job_active = 0;
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the reference.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("ack_onehot0", 128'($countones(bus.req_v_ack) <= 1), 1);
                chk("resp_onehot0", 128'($countones(bus.resp_i_stb) <= 1), 1);
                if (job_active) begin
                    chk("busy_in_job", bus.busy, 1);
                    chk("grant_id", bus.grant_id, exp_grant);
                    chk("am_vec", bus.am_input_v, exp_vec);
                    if (bus.resp_i_stb != '0) begin
                        chk("resp_stb", bus.resp_i_stb, 128'(1) << exp_grant);
                        chk("resp_i", bus.resp_i, exp_idx);
                    end
                end else begin
                    chk("idle_am_stb", bus.am_input_v_stb, 0);
                    chk("idle_resp_stb", bus.resp_i_stb, 0);
                    chk("idle_am_ack", bus.am_output_i_ack, 0);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        for (int r = 0; r < R; r++) begin total[r] = 0; resp_hold[r] = 0; end
        tick; tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic wait_done(input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            tick;
            done = !bus.busy;
            for (int r = 0; r < R; r++)
                if (started[r] != total[r] || bus.req_v_stb[r] || waiting[r]) done = 0;
        end
        chk("wait_done_timeout", done, 1);
    endtask

    task automatic wait_for(input string nm, input int what, input int budget);
        bit hit = 0;
        for (int c = 0; c < budget && !hit; c++) begin
            tick;
            case (what)
                0: hit = (bus.resp_i_stb != '0);
                1: hit = bus.req_v_ack[0];
                default: hit = bus.am_output_i_ack;
            endcase
        end
        chk(nm, hit, 1);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_vack"}, bus.req_v_ack, 0);
        chk({nm, "_rstb"}, bus.resp_i_stb, 0);
        chk({nm, "_amstb"}, bus.am_input_v_stb, 0);
        chk({nm, "_amack"}, bus.am_output_i_ack, 0);
        chk({nm, "_gid"}, bus.grant_id, 0);
        chk({nm, "_resp"}, bus.resp_i, 0);
        chk({nm, "_amv"}, bus.am_input_v, 0);
    endtask

    initial begin
        rst = 1'b0;
        am_lat = 2; iso_cnt = 0; iso_vec = '0;
        for (int r = 0; r < R; r++) begin total[r] = 0; resp_hold[r] = 0; end
        vec_cfg[0] = {F3, F2, F1};
        vec_cfg[1] = {F1, F3, F2};
        tick;
        chk_outputs_zero("reset");
        tick;
        rst = 1'b1;
        tick;

        // 1: single requester, timing of ack and issue
        total[0] = 1;
        tick;
        chk("t1_ack_rise", bus.req_v_ack, 2'b01);
        tick;
        chk("t1_issue_rise", bus.am_input_v_stb, 1);
        chk("t1_ack_drop", bus.req_v_ack, 0);
        wait_done(100);
        chk("t1_nresp", resp_i_log.size(), 1);
        if (resp_i_log.size() >= 1) begin
            chk("t1_resp_r", resp_r_log[0], 0);
            chk("t1_resp_i", resp_i_log[0], 2);
        end
        chk("t1_req1_never_acked", ack1_seen, 0);

        // 2: simultaneous after reset
        do_reset;
        total[0] = 1; total[1] = 1;
        wait_done(200);
        chk("t2_nresp", resp_i_log.size(), 2);
        if (resp_i_log.size() >= 2) begin
            chk("t2_r0", resp_r_log[0], 0); chk("t2_i0", resp_i_log[0], 2);
            chk("t2_r1", resp_r_log[1], 1); chk("t2_i1", resp_i_log[1], 1);
            chk("t2_g0", grant_log[0], 0);  chk("t2_g1", grant_log[1], 1);
        end

        // 3: fairness with both strobes kept busy
        do_reset;
        total[0] = 3; total[1] = 3;
        wait_done(600);
        chk("t3_ngrant", grant_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) chk("t3_grant_order", grant_log[i], i % 2);

        // 4: back-pressure in RETURN
        do_reset;
        resp_hold[0] = 20;
        total[0] = 1; total[1] = 1;
        wait_for("t4_resp_seen", 0, 100);
        for (int i = 0; i < 20; i++) begin
            chk("t4_rstb_stable", bus.resp_i_stb, 2'b01);
            chk("t4_resp_stable", bus.resp_i, 2);
            chk("t4_no_new_ack", bus.req_v_ack, 0);
            chk("t4_no_issue", bus.am_input_v_stb, 0);
            tick;
        end
        wait_done(200);
        chk("t4_nresp", resp_i_log.size(), 2);

        // 5: req_v changes after the transfer must not reach the argmax unit
        do_reset;
        total[0] = 1;
        wait_for("t5_ack_seen", 1, 50);
        tick;
        iso_vec = {F1, F2, F3};
        iso_cnt++;
        wait_done(100);
        chk("t5_nresp", resp_i_log.size(), 1);
        if (resp_i_log.size() >= 1) chk("t5_latched_idx", resp_i_log[0], 2);

        // 6: reset while waiting on the argmax unit
        do_reset;
        am_lat = 10;
        total[1] = 1;
        wait_for("t6_in_wait", 2, 50);
        chk("t6_gid_before", bus.grant_id, 1);
        #1 rst = 1'b0;
        total[1] = 0;
        #1 chk_outputs_zero("t6_async");
        tick;
        rst = 1'b1;
        am_lat = 2;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t6_no_result", bus.resp_i_stb, 0);
            chk("t6_idle", bus.busy, 0);
        end
        total[0] = 1; total[1] = 1;
        wait_done(200);
        chk("t6_ngrant", grant_log.size(), 2);
        if (grant_log.size() >= 1) chk("t6_first_grant", grant_log[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
